// File: rtl/commutation_sequencer.sv
// Six-step commutation sequencer with dead time and shadowed period update.
// Optional STEP_COUNT_EN adds stepCntO, a wrapping count of step advances.
module commutation_sequencer #(
  parameter int PERIOD_W   = 16,
  parameter int DEAD_TICKS = 2
) (
  input  logic                clk50mhzI,
  input  logic                rst,
  input  logic                tick1mhzI,
  input  logic                runI,
  input  logic                dirI,
  input  logic [PERIOD_W-1:0] periodI,
  input  logic                cfgValidI,
  output logic                cfgReadyO,
  output logic [2:0]          phaseHiO,
  output logic [2:0]          phaseLoO,
  output logic [2:0]          stepO,
  output logic                stepPulseO,
  output logic                busyO
`ifdef STEP_COUNT_EN
  ,
  output logic [15:0]         stepCntO
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DEAD  = 2'd2
  } state_t;

  localparam logic [PERIOD_W-1:0] DEAD_LD = PERIOD_W'(DEAD_TICKS);
  localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] PER_RST = PERIOD_W'(1000);

  state_t              state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] shd_q, shd_d;
  logic                full_q, full_d;
  logic                pulse_q, pulse_d;
  logic                boundary;
  logic                adv;
  logic [2:0]          step_nxt;
`ifdef STEP_COUNT_EN
  logic [15:0]         scnt_q, scnt_d;
`endif

  always_ff @(posedge clk50mhzI) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      cnt_q   <= '0;
      per_q   <= PER_RST;
      shd_q   <= '0;
      full_q  <= 1'b0;
      pulse_q <= 1'b0;
`ifdef STEP_COUNT_EN
      scnt_q  <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      shd_q   <= shd_d;
      full_q  <= full_d;
      pulse_q <= pulse_d;
`ifdef STEP_COUNT_EN
      scnt_q  <= scnt_d;
`endif
    end
  end

  always_comb begin
    if (dirI) begin
      step_nxt = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
    end else begin
      step_nxt = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    shd_d    = shd_q;
    full_d   = full_q;
    pulse_d  = 1'b0;
    boundary = 1'b0;
    adv      = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (runI) begin
          state_d  = DRIVE;
          boundary = 1'b1;
        end
      end
      (state_q == DRIVE): begin
        if (!runI) begin
          state_d = DEAD;
          cnt_d   = DEAD_LD;
        end else if (tick1mhzI) begin
          if (cnt_q == ONE) begin
            state_d = DEAD;
            cnt_d   = DEAD_LD;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      (state_q == DEAD): begin
        if (tick1mhzI) begin
          if (cnt_q == ONE) begin
            if (runI) begin
              state_d  = DRIVE;
              step_d   = step_nxt;
              boundary = 1'b1;
              adv      = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Shadow is only consumed if it was full before this cycle's transfer
    if (boundary) begin
      pulse_d = 1'b1;
      if (full_q) begin
        per_d  = shd_q;
        cnt_d  = shd_q;
        full_d = 1'b0;
      end else begin
        cnt_d = per_q;
      end
    end
    if (cfgValidI && !full_q) begin
      shd_d  = (periodI == '0) ? ONE : periodI;
      full_d = 1'b1;
    end
  end

`ifdef STEP_COUNT_EN
  assign scnt_d   = adv ? scnt_q + 16'd1 : scnt_q;
  assign stepCntO = scnt_q;
`endif

  always_comb begin
    phaseHiO = 3'b000;
    phaseLoO = 3'b000;
    if (state_q == DRIVE) begin
      case (step_q)
        3'd0:    begin phaseHiO = 3'b001; phaseLoO = 3'b010; end
        3'd1:    begin phaseHiO = 3'b001; phaseLoO = 3'b100; end
        3'd2:    begin phaseHiO = 3'b010; phaseLoO = 3'b100; end
        3'd3:    begin phaseHiO = 3'b010; phaseLoO = 3'b001; end
        3'd4:    begin phaseHiO = 3'b100; phaseLoO = 3'b001; end
        3'd5:    begin phaseHiO = 3'b100; phaseLoO = 3'b010; end
        default: begin phaseHiO = 3'b000; phaseLoO = 3'b000; end
      endcase
    end
  end

  assign stepO      = step_q;
  assign stepPulseO = pulse_q;
  assign busyO      = (state_q != IDLE);
  assign cfgReadyO  = ~full_q;

endmodule

// File: tb/tb_commutation_sequencer.sv
// Directed table-driven bench for commutation_sequencer.
// Ticks are issued explicitly: one idle cycle, then one tick cycle.
module tb_commutation_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        run = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] per = 16'd0;
  logic        vld = 1'b0;
  logic        rdy;
  logic [2:0]  hi, lo, st;
  logic        pu, bu;
`ifdef STEP_COUNT_EN
  logic [15:0] scnt;
`endif

  int vecs = 0;
  int errs = 0;

  commutation_sequencer #(.PERIOD_W(16), .DEAD_TICKS(2)) dut (
    .clk50mhzI (clk),
    .rst       (rst),
    .tick1mhzI (tick),
    .runI      (run),
    .dirI      (dir),
    .periodI   (per),
    .cfgValidI (vld),
    .cfgReadyO (rdy),
    .phaseHiO  (hi),
    .phaseLoO  (lo),
    .stepO     (st),
    .stepPulseO(pu),
    .busyO     (bu)
`ifdef STEP_COUNT_EN
    ,
    .stepCntO  (scnt)
`endif
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if ((hi & lo) != 3'b000) begin
      errs++;
      $display("FAIL overlap t=%0t hi=%b lo=%b required hi&lo=000",
               $time, hi, lo);
    end
  end

  typedef struct {
    bit rs, r, d, v;
    logic [15:0] p;
    int nt, nc;
    logic [2:0] eh, el, es;
    bit ep, eb, er;
  } vec_t;

  vec_t tv[32];

  function automatic vec_t mk(bit rs, bit r, bit d, bit v,
      logic [15:0] p, int nt, int nc, logic [2:0] eh,
      logic [2:0] el, logic [2:0] es, bit ep, bit eb, bit er);
    vec_t x;
    x.rs = rs; x.r = r; x.d = d; x.v = v; x.p = p;
    x.nt = nt; x.nc = nc; x.eh = eh; x.el = el; x.es = es;
    x.ep = ep; x.eb = eb; x.er = er;
    return x;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic check(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got hi/lo/st/pu/bu/rdy=%b expected %b",
               nm, act, exp);
    end
  endtask

  initial begin
    // rs run dir vld per nt nc | hi lo st pu bu rdy
    tv[0]  = mk(0,1,0,0,0,   0,1, 3'b001,3'b010,0,1,1,1);
    tv[1]  = mk(0,1,0,1,5,   0,0, 3'b001,3'b010,0,0,1,0);
    tv[2]  = mk(0,1,0,0,0, 999,0, 3'b001,3'b010,0,0,1,0);
    tv[3]  = mk(0,1,0,0,0,   1,0, 3'b000,3'b000,0,0,1,0);
    tv[4]  = mk(0,1,0,0,0,   1,0, 3'b000,3'b000,0,0,1,0);
    tv[5]  = mk(0,1,0,0,0,   1,0, 3'b001,3'b100,1,1,1,1);
    tv[6]  = mk(0,1,0,0,0,   4,0, 3'b001,3'b100,1,0,1,1);
    tv[7]  = mk(0,1,0,0,0,   1,0, 3'b000,3'b000,1,0,1,1);
    tv[8]  = mk(0,1,0,0,0,   2,0, 3'b010,3'b100,2,1,1,1);
    tv[9]  = mk(0,1,0,0,0,   1,0, 3'b010,3'b100,2,0,1,1);
    tv[10] = mk(0,0,0,0,0,   0,1, 3'b000,3'b000,2,0,1,1);
    tv[11] = mk(0,0,0,0,0,   2,0, 3'b000,3'b000,2,0,0,1);
    tv[12] = mk(0,1,0,0,0,   0,1, 3'b010,3'b100,2,1,1,1);
    tv[13] = mk(0,0,0,0,0,   0,1, 3'b000,3'b000,2,0,1,1);
    tv[14] = mk(0,0,0,0,0,   2,0, 3'b000,3'b000,2,0,0,1);
    tv[15] = mk(0,1,0,0,0,   0,1, 3'b010,3'b100,2,1,1,1);
    tv[16] = mk(0,1,0,0,0,   5,0, 3'b000,3'b000,2,0,1,1);
    tv[17] = mk(0,1,0,0,0,   2,0, 3'b010,3'b001,3,1,1,1);
    tv[18] = mk(0,1,0,0,0,   2,0, 3'b010,3'b001,3,0,1,1);
    tv[19] = mk(1,0,0,0,0,   0,0, 3'b000,3'b000,0,0,0,1);
    tv[20] = mk(0,0,1,1,3,   0,0, 3'b000,3'b000,0,0,0,0);
    tv[21] = mk(0,1,1,0,0,   0,1, 3'b001,3'b010,0,1,1,1);
    tv[22] = mk(0,1,1,0,0,   3,0, 3'b000,3'b000,0,0,1,1);
    tv[23] = mk(0,1,1,0,0,   2,0, 3'b100,3'b010,5,1,1,1);
    tv[24] = mk(0,1,1,0,0,   5,0, 3'b100,3'b001,4,1,1,1);
    tv[25] = mk(0,1,1,0,0,   5,0, 3'b010,3'b001,3,1,1,1);
    tv[26] = mk(0,1,0,1,0,   0,0, 3'b010,3'b001,3,0,1,0);
    tv[27] = mk(0,1,0,0,0,   5,0, 3'b100,3'b001,4,1,1,1);
    tv[28] = mk(0,1,0,0,0,   1,0, 3'b000,3'b000,4,0,1,1);
    tv[29] = mk(0,1,0,0,0,   2,0, 3'b100,3'b010,5,1,1,1);
    tv[30] = mk(0,1,0,0,0,   3,0, 3'b001,3'b010,0,1,1,1);
    tv[31] = mk(0,1,0,0,0,   3,0, 3'b001,3'b100,1,1,1,1);

    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check("reset", {hi, lo, st, pu, bu, rdy},
          {3'b000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1});
`ifdef STEP_COUNT_EN
    vecs++;
    if (scnt !== 16'd0) begin
      errs++;
      $display("FAIL stepcnt_reset got %0d expected 0", scnt);
    end
`endif

    for (int i = 0; i < 32; i++) begin
      run = tv[i].r;
      dir = tv[i].d;
      per = tv[i].p;
      if (tv[i].rs) begin
        rst  = 1'b1;
        tick = 1'b1;
        cyc();
        rst  = 1'b0;
        tick = 1'b0;
      end
      if (tv[i].v) begin
        vld = 1'b1;
        cyc();
        vld = 1'b0;
      end
      tick_n(tv[i].nt);
      repeat (tv[i].nc) cyc();
      check($sformatf("vec%0d", i), {hi, lo, st, pu, bu, rdy},
            {tv[i].eh, tv[i].el, tv[i].es, tv[i].ep, tv[i].eb, tv[i].er});
`ifdef STEP_COUNT_EN
      if (tv[i].rs) begin
        vecs++;
        if (scnt !== 16'd0) begin
          errs++;
          $display("FAIL stepcnt_rst got %0d expected 0", scnt);
        end
      end
`endif
    end

`ifdef STEP_COUNT_EN
    vecs++;
    if (scnt !== 16'd7) begin
      errs++;
      $display("FAIL stepcnt_adv got %0d expected 7", scnt);
    end
`endif

    // Stop from DRIVE, gates must drop immediately and idle after dead time
    run = 1'b0;
    cyc();
    check("stop_dead", {hi, lo, st, pu, bu, rdy},
          {3'b000, 3'b000, 3'd1, 1'b0, 1'b1, 1'b1});
    tick_n(2);
    check("stop_idle", {hi, lo, st, pu, bu, rdy},
          {3'b000, 3'b000, 3'd1, 1'b0, 1'b0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/commutation_sequencer.md
Name: commutation_sequencer

Overview:
- Six-step three-phase commutation controller for the motor drive, clocked from the 50 MHz board clock.
- Uses the 1 MHz timebase from the clock divider as a single-cycle tick enable, not as a clock.
- Sequences high-side/low-side gate enables with a programmable step period and inserted dead time.
- Accepts period updates via a valid/ready handshake and applies them only at step boundaries.

Parameters:
- PERIOD_W, 16, width of the step-period value, in 1 MHz ticks.
- DEAD_TICKS, 2, dead-time length in ticks between successive steps (1..15).

Ports:
- clk50mhzI  input  1  50 MHz system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tick1mhzI  input  1  one-clk50mhzI-cycle pulse at 1 MHz; all timing counts these pulses.
- runI  input  1  level; 1 = commutate, 0 = stop.
- dirI  input  1  0 = forward (step +1), 1 = reverse (step -1), sampled at each step advance.
- periodI  input  PERIOD_W  requested step period in ticks.
- cfgValidI  input  1  periodI valid.
- cfgReadyO  output  1  shadow register free to accept a period.
- phaseHiO  output  3  high-side enables {C,B,A}.
- phaseLoO  output  3  low-side enables {C,B,A}.
- stepO  output  3  current step index, 0..5.
- stepPulseO  output  1  one-cycle pulse when a new step begins driving.
- busyO  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clock edge), synchronous:
  - state = IDLE; phaseHiO, phaseLoO, stepO, stepPulseO, busyO = 0; cfgReadyO = 1.
  - Active period = 1000; shadow empty; tick counter = 0.
  - Reset mid-step forces all gates off in the next cycle.
- Config handshake:
  - Transfer occurs on a cycle where cfgValidI & cfgReadyO are both 1. periodI is latched into the shadow register, shadow becomes full, and cfgReadyO drops the next cycle.
  - At the next step boundary (DEAD->DRIVE, or IDLE->DRIVE) the shadow is copied to the active period, shadow becomes empty, and cfgReadyO returns to 1 the cycle after.
  - A period value of 0 is treated as 1.
- Step table, as {A,B,C} pairs:
  - Step 0: Hi=A, Lo=B. Step 1: Hi=A, Lo=C. Step 2: Hi=B, Lo=C.
  - Step 3: Hi=B, Lo=A. Step 4: Hi=C, Lo=A. Step 5: Hi=C, Lo=B.
- FSM:
  - IDLE: gates off. When runI=1, go to DRIVE on the next cycle with stepO unchanged, and pulse stepPulseO.
  - DRIVE: gates follow the table for stepO. The counter loads the active period on entry and decrements on each tick1mhzI. When a tick arrives with count=1, go to DEAD.
  - DEAD: all gates 0. The counter loads DEAD_TICKS and decrements on ticks. On expiry:
    - if runI=1, advance stepO (forward 5->0, reverse 0->5), go to DRIVE, pulse stepPulseO;
    - else go to IDLE.
- runI=0 while in DRIVE: go to DEAD on the next cycle, then IDLE after the dead time. Gates never go directly from on to IDLE.
- A high-side and low-side enable on the same phase is never simultaneously 1. Any phase change passes through DEAD.
- Simultaneous events:
  - cfg transfer on the same cycle as a boundary: the new value waits for the following boundary.
  - tick1mhzI with rst: rst wins.

Optional Feature:
- Macro STEP_COUNT_EN.
- When defined:
  - adds output stepCntO [15:0], the count of step advances since reset;
  - increments on each stepPulseO that follows DEAD (not on IDLE->DRIVE);
  - wraps 65535->0; resets to 0.
- When undefined: the port and counter are absent, with no other change.

Test Plan:
- Reset then runI=1, default period 1000, DEAD_TICKS=2 -> step 0 (Hi=001, Lo=010) for 1000 ticks, gates 000/000 for 2 ticks, then step 1 (Hi=001, Lo=100) with stepPulseO.
- Handshake periodI=5 mid-step 0 -> cfgReadyO=0 until the step-1 boundary. Step 0 keeps 1000 ticks; step 1 lasts 5 ticks; cfgReadyO=1 the cycle after the boundary.
- dirI=1 starting at step 0, period 3 -> step sequence 0,5,4,3; wrap verified.
- runI dropped 1 tick into step 2 -> DEAD next cycle, IDLE after 2 ticks, busyO=0, stepO stays 2. Re-run resumes at step 2.
- periodI=0 -> each step drives exactly 1 tick. Checker asserts (phaseHiO & phaseLoO)==0 on every cycle.
- rst pulsed during DRIVE of step 3 -> next cycle all outputs 0 and stepO=0. With STEP_COUNT_EN, stepCntO=0, and after 7 advances stepCntO=7.
